// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types and constants for the load/store unit
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [3:0] WSTRB_WORD = 4'b1111;
    localparam logic [3:0] WSTRB_NONE = 4'b0000;

    // Only word accesses have an alignment requirement; byte accesses may hit any lane.
    function automatic logic is_misaligned(input logic is_byte, input logic [1:0] offset);
        return !is_byte && (offset != 2'b00);
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// rtl/byte_lane_align.sv - byte-lane steering for stores and lane extraction/sign extension for loads
module byte_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic        i_is_byte,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_load_data
);

    logic [7:0] w_lane;

    always_comb begin
        w_lane = i_rdata[7:0];
        case (i_offset)
            2'd0:    w_lane = i_rdata[7:0];
            2'd1:    w_lane = i_rdata[15:8];
            2'd2:    w_lane = i_rdata[23:16];
            default: w_lane = i_rdata[31:24];
        endcase
    end

    always_comb begin
        o_load_data = i_rdata;
        o_wdata     = i_store_data;
        o_wstrb     = WSTRB_WORD;
        if (i_is_byte) begin
            o_load_data = {{24{w_lane[7]}}, w_lane};
            o_wdata     = {4{i_store_data[7:0]}};
            o_wstrb     = 4'b0001 << i_offset;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit with IDLE/BUSY/DONE handshake to a single-ack memory bus
// Optional bus-ack timeout abort is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_mem,
    input  logic        write_mem,
    input  logic        load_byte,
    input  logic        store_byte,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    output logic        bus_ren,
    output logic        bus_wen,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] load_data,
    output logic        mem_stall,
    output logic        mem_error
);

    lsu_state_t  r_state;
    lsu_state_t  w_next_state;
    logic [31:0] r_addr;
    logic [31:0] r_store_data;
    logic [31:0] r_load_data;
    logic        r_is_store;
    logic        r_is_byte;
    logic        r_mem_error;

    logic        w_req;
    logic        w_req_byte;
    logic        w_misaligned;
    logic        w_timeout;
    logic        w_err_next;
    logic        w_capture;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_load_aligned;

    // A simultaneous read and write request is treated as a store.
    assign w_req        = read_mem | write_mem;
    assign w_req_byte   = write_mem ? store_byte : load_byte;
    assign w_misaligned = is_misaligned(w_req_byte, addr[1:0]);

    byte_lane_align u_align (
        .i_offset     (r_addr[1:0]),
        .i_is_byte    (r_is_byte),
        .i_store_data (r_store_data),
        .i_rdata      (bus_rdata),
        .o_wdata      (w_wdata),
        .o_wstrb      (w_wstrb),
        .o_load_data  (w_load_aligned)
    );

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || (r_state != BUSY)) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == BUSY) && (r_wait_cnt == TIMEOUT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_err_next   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_misaligned) begin
                        w_next_state = DONE;
                        w_err_next   = 1'b1;
                    end else begin
                        w_next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus_ack) begin
                    w_next_state = DONE;
                    w_capture    = !r_is_store;
                end else if (w_timeout) begin
                    w_next_state = DONE;
                    w_err_next   = 1'b1;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_store_data <= '0;
            r_load_data  <= '0;
            r_is_store   <= 1'b0;
            r_is_byte    <= 1'b0;
            r_mem_error  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_mem_error <= w_err_next;
            if ((r_state == IDLE) && w_req && !w_misaligned) begin
                r_addr       <= addr;
                r_store_data <= store_data;
                r_is_store   <= write_mem;
                r_is_byte    <= w_req_byte;
            end
            if (w_capture) begin
                r_load_data <= w_load_aligned;
            end
        end
    end

    // Bus requests are gated by rst so they drop in the reset cycle itself.
    assign bus_ren   = (r_state == BUSY) && !r_is_store && !rst;
    assign bus_wen   = (r_state == BUSY) &&  r_is_store && !rst;
    assign bus_wstrb = bus_wen ? w_wstrb : WSTRB_NONE;
    assign bus_wdata = w_wdata;
    assign bus_addr  = {r_addr[31:2], 2'b00};
    assign mem_stall = (r_state == BUSY) || ((r_state == IDLE) && w_req);
    assign load_data = r_load_data;
    assign mem_error = r_mem_error;

endmodule
